// File: rtl/uart_speed_pkg.sv
// uart_speed_pkg: shared types and helpers for the uart_speed_rx receiver.
//   HDR_BYTE_DEF     default frame header value
//   byte_state_t     byte deserialiser states
//   parse_state_t    speed-frame parser states
//   clks_per_bit()   system clocks per UART bit, truncated
//   frame_chk()      frame checksum, XOR of header, hi and lo bytes
package uart_speed_pkg;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_state_t;

  typedef enum logic [1:0] {
    P_WAIT_HDR,
    P_GET_HI,
    P_GET_LO,
    P_GET_CHK
  } parse_state_t;

  function automatic int clks_per_bit(input int sys_freq, input int baud);
    return sys_freq / baud;
  endfunction

  function automatic logic [7:0] frame_chk(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [7:0] c);
    return a ^ b ^ c;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: two-flop synchroniser plus 8N1 byte deserialiser.
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high
//   serial_data_in UART line, idles high, asynchronous to clk
//   byte_data      last good byte
//   byte_valid     one-cycle strobe per good byte
//   stop_err       one-cycle strobe when the stop bit is sampled low
//   active         high while the byte FSM is not IDLE
module uart_rx_byte
  import uart_speed_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_data_in,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       stop_err,
  output logic       active
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_m, rx_s, rx_d;
  byte_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic             half_tick, full_tick, fall, stop_done;

  // synchroniser; rx_d is the previous synchronised sample for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= serial_data_in;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign half_tick = (cnt == CNT_HALF);
  assign full_tick = (cnt == CNT_FULL);
  // only a high-to-low transition starts a byte, so a held-low break
  // cannot retrigger after its single stop error
  assign fall      = rx_d & ~rx_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= B_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      B_IDLE:  if (fall) state_nxt = B_START;
      B_START: if (half_tick) state_nxt = rx_s ? B_IDLE : B_DATA;
      B_DATA:  if (full_tick && idx == 3'd7) state_nxt = B_STOP;
      B_STOP:  if (full_tick) state_nxt = B_IDLE;
      default: state_nxt = B_IDLE;
    endcase
  end

  always_comb begin
    active    = (state != B_IDLE);
    stop_done = (state == B_STOP) && full_tick;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      byte_valid <= stop_done & rx_s;
      stop_err   <= stop_done & ~rx_s;
      if (stop_done && rx_s) byte_data <= shreg;
      case (state)
        B_IDLE: cnt <= '0;
        B_START: begin
          if (half_tick) begin
            cnt <= '0;
            idx <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        B_DATA: begin
          if (full_tick) begin
            cnt <= '0;
            idx <= idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        B_STOP: cnt <= full_tick ? '0 : cnt + 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  // shift register carries payload only; a reset mid-byte never reaches byte_data
  always_ff @(posedge clk) begin
    if (state == B_DATA && full_tick) shreg <= {rx_s, shreg[7:1]};
  end

endmodule

// File: rtl/uart_speed_rx.sv
// uart_speed_rx: receives header/speed-hi/speed-lo/checksum frames over 8N1 UART.
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high
//   serial_data_in UART line, idles high
//   speed          last validated speed (0.1 km/h units), holds between frames
//   speed_valid    one-cycle strobe when speed updates
//   frame_err      one-cycle strobe per framing/checksum/range/timeout error
//   byte_data      last received byte
//   byte_valid     one-cycle strobe per good byte
//   busy           byte FSM not IDLE or parser not WAIT_HDR
module uart_speed_rx
  import uart_speed_pkg::*;
#(
  parameter int         SYS_FREQ     = 50000000,
  parameter int         BAUD         = 9600,
  parameter int         WIDTH_SPEED  = 14,
  parameter logic [7:0] HDR_BYTE     = HDR_BYTE_DEF,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   serial_data_in,
  output logic [WIDTH_SPEED-1:0] speed,
  output logic                   speed_valid,
  output logic                   frame_err,
  output logic [7:0]             byte_data,
  output logic                   byte_valid,
  output logic                   busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(SYS_FREQ, BAUD);
  localparam int GAP_LIMIT    = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int GAP_W        = $clog2(GAP_LIMIT + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_LIMIT);
  // hi-byte bits above the speed field must be zero
  localparam logic [7:0] HI_MASK = 8'(8'hFF << (WIDTH_SPEED - 8));

  logic             rx_active, rx_stop_err;
  parse_state_t     pstate, pstate_nxt;
  logic [7:0]       hi, lo;
  logic [GAP_W-1:0] gap;
  logic             timeout, hi_bad, chk_ok;
  logic             err_nxt, spd_nxt;
  logic [15:0]      frame_word;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clk           (clk),
    .reset         (reset),
    .serial_data_in(serial_data_in),
    .byte_data     (byte_data),
    .byte_valid    (byte_valid),
    .stop_err      (rx_stop_err),
    .active        (rx_active)
  );

  assign hi_bad     = (byte_data & HI_MASK) != 8'h00;
  assign chk_ok     = (byte_data == frame_chk(HDR_BYTE, hi, lo));
  assign frame_word = {hi, lo};
  // a byte arriving in the expiry cycle wins over the timeout
  assign timeout    = (pstate != P_WAIT_HDR) && !byte_valid && (gap == GAP_MAX);
  assign busy       = rx_active || (pstate != P_WAIT_HDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pstate <= P_WAIT_HDR;
    else       pstate <= pstate_nxt;
  end

  always_comb begin
    pstate_nxt = pstate;
    if (rx_stop_err || timeout) begin
      pstate_nxt = P_WAIT_HDR;
    end else if (byte_valid) begin
      case (pstate)
        P_WAIT_HDR: if (byte_data == HDR_BYTE) pstate_nxt = P_GET_HI;
        P_GET_HI:   pstate_nxt = hi_bad ? P_WAIT_HDR : P_GET_LO;
        P_GET_LO:   pstate_nxt = P_GET_CHK;
        P_GET_CHK:  pstate_nxt = P_WAIT_HDR;
        default:    pstate_nxt = P_WAIT_HDR;
      endcase
    end
  end

  always_comb begin
    spd_nxt = byte_valid && (pstate == P_GET_CHK) && chk_ok;
    err_nxt = rx_stop_err || timeout
           || (byte_valid && (pstate == P_GET_HI) && hi_bad)
           || (byte_valid && (pstate == P_GET_CHK) && !chk_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      speed       <= '0;
      speed_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      speed_valid <= spd_nxt;
      frame_err   <= err_nxt;
      if (spd_nxt) speed <= frame_word[WIDTH_SPEED-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (byte_valid && pstate == P_GET_HI) hi <= byte_data;
    if (byte_valid && pstate == P_GET_LO) lo <= byte_data;
  end

  // inter-byte gap: counts line-idle time inside a frame, saturates at expiry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap <= '0;
    end else if (byte_valid || timeout || pstate == P_WAIT_HDR) begin
      gap <= '0;
    end else if (!rx_active && gap != GAP_MAX) begin
      gap <= gap + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_speed_rx.sv
module tb_uart_speed_rx;
  localparam int SYS_FREQ     = 1600;
  localparam int BAUD         = 100;
  localparam int CPB          = SYS_FREQ / BAUD;
  localparam int WIDTH_SPEED  = 14;
  localparam int TIMEOUT_BITS = 20;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   serial_data_in;
  logic [WIDTH_SPEED-1:0] speed;
  logic                   speed_valid, frame_err, byte_valid, busy;
  logic [7:0]             byte_data;

  typedef struct packed {
    logic        is_err;
    logic [15:0] val;
  } ev_t;

  ev_t        ev_q[$];
  logic [7:0] byte_q[$];
  ev_t        ev;
  int checks = 0, failures = 0;
  int n_byte = 0, n_spd = 0, n_err = 0;
  int b0, e0, s0;

  uart_speed_rx #(
    .SYS_FREQ    (SYS_FREQ),
    .BAUD        (BAUD),
    .WIDTH_SPEED (WIDTH_SPEED),
    .HDR_BYTE    (8'hA5),
    .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .serial_data_in(serial_data_in),
    .speed         (speed),
    .speed_valid   (speed_valid),
    .frame_err     (frame_err),
    .byte_data     (byte_data),
    .byte_valid    (byte_valid),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // scoreboard side: every strobe pops and compares against the queued expectation
  always @(negedge clk) begin
    if (!reset) begin
      if (byte_valid) begin
        n_byte++;
        check_eq("byte_pending", (byte_q.size() > 0), 1);
        if (byte_q.size() > 0) check_eq("byte_data", byte_data, byte_q.pop_front());
      end
      if (speed_valid || frame_err) begin
        check_eq("strobe_overlap", speed_valid & frame_err, 0);
        check_eq("event_pending", (ev_q.size() > 0), 1);
        if (ev_q.size() > 0) begin
          ev = ev_q.pop_front();
          if (speed_valid) begin
            n_spd++;
            check_eq("speed_event_kind", ev.is_err, 0);
            check_eq("speed_value", speed, ev.val);
          end else begin
            n_err++;
            check_eq("err_event_kind", ev.is_err, 1);
          end
        end
      end
    end
  end

  task automatic push_ev(input logic is_err, input logic [15:0] val);
    ev_t e;
    e.is_err = is_err;
    e.val    = val;
    ev_q.push_back(e);
  endtask

  task automatic idle_bits(input int n);
    serial_data_in = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    serial_data_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_data_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    serial_data_in = stop_bit;
    repeat (CPB) @(negedge clk);
    serial_data_in = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [7:0] hi,
                            input logic [7:0] lo, input logic [7:0] ck);
    byte_q.push_back(h);
    byte_q.push_back(hi);
    byte_q.push_back(lo);
    byte_q.push_back(ck);
    send_byte(h, 1'b1);
    send_byte(hi, 1'b1);
    send_byte(lo, 1'b1);
    send_byte(ck, 1'b1);
    idle_bits(2);
  endtask

  initial begin
    reset          = 1'b1;
    serial_data_in = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_speed", speed, 0);
    check_eq("rst_speed_valid", speed_valid, 0);
    check_eq("rst_frame_err", frame_err, 0);
    check_eq("rst_byte_data", byte_data, 0);
    check_eq("rst_byte_valid", byte_valid, 0);
    check_eq("rst_busy", busy, 0);
    reset = 1'b0;
    idle_bits(1);

    // good frame -> 225
    b0 = n_byte; e0 = n_err; s0 = n_spd;
    push_ev(1'b0, 16'd225);
    send_frame(8'hA5, 8'h00, 8'hE1, 8'h44);
    check_eq("f1_bytes", n_byte - b0, 4);
    check_eq("f1_speed_pulses", n_spd - s0, 1);
    check_eq("f1_errs", n_err - e0, 0);
    check_eq("f1_speed", speed, 225);
    check_eq("f1_busy", busy, 0);

    // bad checksum, speed holds; then good frame -> 300
    e0 = n_err;
    push_ev(1'b1, 16'd0);
    send_frame(8'hA5, 8'h00, 8'hE1, 8'h45);
    check_eq("bad_chk_errs", n_err - e0, 1);
    check_eq("bad_chk_speed_hold", speed, 225);
    push_ev(1'b0, 16'd300);
    send_frame(8'hA5, 8'h01, 8'h2C, 8'h88);
    check_eq("f3_speed", speed, 300);

    // short low glitch on idle line
    b0 = n_byte; e0 = n_err;
    serial_data_in = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    serial_data_in = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("glitch_busy_start", busy, 1);
    repeat (CPB / 2 + 4) @(negedge clk);
    check_eq("glitch_busy_end", busy, 0);
    check_eq("glitch_bytes", n_byte - b0, 0);
    check_eq("glitch_errs", n_err - e0, 0);

    // stop bit low mid-frame, then recovery
    e0 = n_err;
    byte_q.push_back(8'hA5);
    push_ev(1'b1, 16'd0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b0);
    idle_bits(2);
    check_eq("stop_err_errs", n_err - e0, 1);
    check_eq("stop_err_busy", busy, 0);
    push_ev(1'b0, 16'd225);
    send_frame(8'hA5, 8'h00, 8'hE1, 8'h44);
    check_eq("after_stop_err_speed", speed, 225);

    // inter-byte timeout
    e0 = n_err;
    byte_q.push_back(8'hA5);
    push_ev(1'b1, 16'd0);
    send_byte(8'hA5, 1'b1);
    repeat (2) @(negedge clk);
    check_eq("timeout_armed_busy", busy, 1);
    idle_bits(TIMEOUT_BITS + 1);
    check_eq("timeout_errs", n_err - e0, 1);
    check_eq("timeout_busy", busy, 0);

    // out-of-range hi byte; remaining bytes are not headers
    b0 = n_byte; e0 = n_err;
    push_ev(1'b1, 16'd0);
    send_frame(8'hA5, 8'h40, 8'hE1, 8'h04);
    check_eq("hi_bad_bytes", n_byte - b0, 4);
    check_eq("hi_bad_errs", n_err - e0, 1);
    check_eq("hi_bad_speed_hold", speed, 225);
    check_eq("hi_bad_busy", busy, 0);

    // reset in the middle of the data bits
    serial_data_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      serial_data_in = i[0];
      repeat (CPB) @(negedge clk);
    end
    check_eq("mid_byte_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("midrst_speed", speed, 0);
    check_eq("midrst_byte_data", byte_data, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_strobes", {speed_valid, frame_err, byte_valid}, 0);
    serial_data_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    b0 = n_byte; e0 = n_err; s0 = n_spd;
    idle_bits(12);
    check_eq("post_rst_bytes", n_byte - b0, 0);
    check_eq("post_rst_errs", n_err - e0, 0);
    check_eq("post_rst_spd", n_spd - s0, 0);
    check_eq("post_rst_speed", speed, 0);

    check_eq("events_left", ev_q.size(), 0);
    check_eq("bytes_left", byte_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
